// File: rtl/elliptic_curve_structs.sv
// Shared elliptic-curve point types for the point-multiplication datapath.
// The point at infinity is encoded as (0,0), which is never on a curve with b != 0.
package elliptic_curve_structs;

    localparam int COORD_WIDTH  = 16;
    localparam int SCALAR_WIDTH = 16;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
    } curve_point_t;

    localparam curve_point_t inf_point = '{x: '0, y: '0};

endpackage

// File: rtl/dispatcher_start_pulse.sv
// Start/blank/run sequencer for an external engine: one-cycle start pulse, one
// blank cycle, then the engine's completion level is trusted until it is seen.
module dispatcher_start_pulse (
    input  logic clk,
    input  logic Reset_n,
    input  logic launch,
    input  logic done,
    output logic start,
    output logic fire
);

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_START, SEQ_BLANK, SEQ_RUN} seq_state_t;

    seq_state_t state;

    // NOTE: state and the start pulse use non-blocking assignments so every reader in the same edge sees pre-edge values.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= SEQ_IDLE;
            start <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (launch) begin
                        state <= SEQ_START;
                        start <= 1'b1;
                    end
                end
                SEQ_START: state <= SEQ_BLANK;
                SEQ_BLANK: state <= SEQ_RUN;
                SEQ_RUN:   if (done) state <= SEQ_IDLE;
                default:   state <= SEQ_IDLE;
            endcase
        end
    end

    // A done level left over from an earlier (or abandoned) operation is masked until the run phase.
    assign fire = (state == SEQ_RUN) && done;

endmodule

// File: rtl/point_mul_dispatcher.sv
// Multi-scalar-multiplication dispatcher: feeds jobs to an external multiplier and
// accumulates the products through an external point adder, one batch at a time.
module point_mul_dispatcher
    import elliptic_curve_structs::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  curve_point_t            in_P,
    input  logic [SCALAR_WIDTH-1:0] in_k,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output curve_point_t            out_R,
    output logic [COUNT_W-1:0]      out_count,
    output logic                    mul_Reset,
    output curve_point_t            mul_P,
    output logic [SCALAR_WIDTH-1:0] mul_k,
    input  logic                    mul_Done,
    input  curve_point_t            mul_R,
    output logic                    add_Reset,
    output curve_point_t            add_P,
    output curve_point_t            add_Q,
    input  logic                    add_Done,
    input  curve_point_t            add_R
);

    typedef enum logic [2:0] {M_IDLE, M_START, M_BLANK, M_RUN, M_HOLD} mul_state_t;
    typedef enum logic [2:0] {A_IDLE, A_START, A_BLANK, A_RUN, A_OUT} acc_state_t;

    mul_state_t                m_state;
    acc_state_t                a_state;
    curve_point_t              op_P;
    logic [SCALAR_WIDTH-1:0]   op_k;
    logic                      op_last;
    logic                      last_pending;
    curve_point_t              prod;
    logic                      prod_null;
    curve_point_t              acc;
    logic                      acc_empty;
    curve_point_t              addend;
    logic                      tok_last;
    logic [COUNT_W-1:0]        count;

    logic accept, hand, out_hs, mul_launch, add_launch, mul_fire, add_fire;

    assign accept     = in_valid && in_ready;
    assign hand       = (m_state == M_HOLD) && (a_state == A_IDLE);
    assign out_hs     = out_valid && out_ready;
    assign mul_launch = accept && (in_k > SCALAR_WIDTH'(1));
    assign add_launch = hand && !prod_null && !acc_empty;

    dispatcher_start_pulse u_mul_seq (
        .clk    (clk),
        .Reset_n(Reset_n),
        .launch (mul_launch),
        .done   (mul_Done),
        .start  (mul_Reset),
        .fire   (mul_fire)
    );

    dispatcher_start_pulse u_add_seq (
        .clk    (clk),
        .Reset_n(Reset_n),
        .launch (add_launch),
        .done   (add_Done),
        .start  (add_Reset),
        .fire   (add_fire)
    );

    // MUL: accepts jobs, resolves trivial scalars locally, holds the product until ACC takes it.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_state      <= M_IDLE;
            in_ready     <= 1'b0;
            last_pending <= 1'b0;
            op_P         <= '0;
            op_k         <= '0;
            op_last      <= 1'b0;
            prod         <= '0;
            prod_null    <= 1'b0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (accept) begin
                        op_P         <= in_P;
                        op_k         <= in_k;
                        op_last      <= in_last;
                        last_pending <= in_last;
                        prod_null    <= (in_k == '0);
                        if (in_k == '0) begin
                            // A zero scalar contributes nothing; only a final one must reach ACC.
                            if (in_last) begin
                                m_state  <= M_HOLD;
                                in_ready <= 1'b0;
                            end
                        end else if (in_k == SCALAR_WIDTH'(1)) begin
                            prod     <= in_P;
                            m_state  <= M_HOLD;
                            in_ready <= 1'b0;
                        end else begin
                            m_state  <= M_START;
                            in_ready <= 1'b0;
                        end
                    end else if (out_hs) begin
                        last_pending <= 1'b0;
                        in_ready     <= 1'b1;
                    end else begin
                        in_ready <= !last_pending;
                    end
                end
                M_START: m_state <= M_BLANK;
                M_BLANK: m_state <= M_RUN;
                M_RUN: begin
                    if (mul_fire) begin
                        prod    <= mul_R;
                        m_state <= M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (hand) begin
                        m_state  <= M_IDLE;
                        in_ready <= !last_pending;
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // ACC: folds each product into the running sum and presents the batch result.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_state   <= A_IDLE;
            acc       <= inf_point;
            acc_empty <= 1'b1;
            addend    <= '0;
            tok_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    if (hand) begin
                        tok_last <= op_last;
                        if (prod_null || acc_empty) begin
                            if (!prod_null) begin
                                acc       <= prod;
                                acc_empty <= 1'b0;
                            end
                            if (op_last) begin
                                a_state   <= A_OUT;
                                out_valid <= 1'b1;
                            end
                        end else begin
                            addend  <= prod;
                            a_state <= A_START;
                        end
                    end
                end
                A_START: a_state <= A_BLANK;
                A_BLANK: a_state <= A_RUN;
                A_RUN: begin
                    if (add_fire) begin
                        acc <= add_R;
                        if (tok_last) begin
                            a_state   <= A_OUT;
                            out_valid <= 1'b1;
                        end else begin
                            a_state <= A_IDLE;
                        end
                    end
                end
                A_OUT: begin
                    if (out_ready) begin
                        acc       <= inf_point;
                        acc_empty <= 1'b1;
                        out_valid <= 1'b0;
                        a_state   <= A_IDLE;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (out_hs) begin
            count <= '0;
        end else if (accept) begin
            count <= count + COUNT_W'(1);
        end
    end

    assign mul_P     = op_P;
    assign mul_k     = op_k;
    assign add_P     = acc;
    assign add_Q     = addend;
    assign out_R     = acc;
    assign out_count = count;

endmodule

// File: tb/tb_point_mul_dispatcher.sv
// Self-checking bench: directed batch table, multi-cycle corner sequences and
// randomized batches scored against an arithmetic sum-of-products model.
module tb_point_mul_dispatcher;
    import elliptic_curve_structs::*;

    localparam int CW   = 3;
    localparam int MAXJ = 10;

    typedef struct packed {
        curve_point_t            P;
        logic [SCALAR_WIDTH-1:0] k;
    } job_t;

    typedef struct {
        int           n;
        job_t         j[MAXJ];
        curve_point_t exp_R;
        int           exp_cnt;
        int           exp_muls;
        int           exp_adds;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    Reset_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    curve_point_t            in_P = '0;
    logic [SCALAR_WIDTH-1:0] in_k = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    curve_point_t            out_R;
    logic [CW-1:0]           out_count;
    logic                    mul_Reset;
    curve_point_t            mul_P;
    logic [SCALAR_WIDTH-1:0] mul_k;
    logic                    mul_Done = 1'b0;
    curve_point_t            mul_R = '0;
    logic                    add_Reset;
    curve_point_t            add_P;
    curve_point_t            add_Q;
    logic                    add_Done = 1'b0;
    curve_point_t            add_R = '0;

    always #5 clk = ~clk;

    point_mul_dispatcher #(.COUNT_W(CW)) dut (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_P     (in_P),
        .in_k     (in_k),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_R    (out_R),
        .out_count(out_count),
        .mul_Reset(mul_Reset),
        .mul_P    (mul_P),
        .mul_k    (mul_k),
        .mul_Done (mul_Done),
        .mul_R    (mul_R),
        .add_Reset(add_Reset),
        .add_P    (add_P),
        .add_Q    (add_Q),
        .add_Done (add_Done),
        .add_R    (add_R)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Group-law stand-ins: component-wise arithmetic mod 2^16 with (0,0) as identity.
    function automatic curve_point_t pt_scale(input curve_point_t p, input logic [SCALAR_WIDTH-1:0] k);
        logic [31:0] x, y;
        x = 32'(p.x) * 32'(k);
        y = 32'(p.y) * 32'(k);
        return '{x: x[15:0], y: y[15:0]};
    endfunction

    function automatic curve_point_t pt_add(input curve_point_t a, input curve_point_t b);
        return '{x: a.x + b.x, y: a.y + b.y};
    endfunction

    // External engines: the start pulse is registered inside, so the old done level
    // persists through the blank cycle; results are junk until done rises.
    int           mul_lat = 2, add_lat = 2;
    logic         m_go = 1'b0, a_go = 1'b0;
    int           m_cnt = 0, a_cnt = 0;
    curve_point_t m_res = '0, a_res = '0;

    always @(posedge clk) begin
        m_go <= mul_Reset;
        if (m_go) begin
            mul_Done <= 1'b0;
            m_cnt    <= mul_lat;
            m_res    <= pt_scale(mul_P, mul_k);
            mul_R    <= curve_point_t'($urandom);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_Done <= 1'b1;
                mul_R    <= m_res;
            end
        end
    end

    always @(posedge clk) begin
        a_go <= add_Reset;
        if (a_go) begin
            add_Done <= 1'b0;
            a_cnt    <= add_lat;
            a_res    <= pt_add(add_P, add_Q);
            add_R    <= curve_point_t'($urandom);
        end else if (a_cnt > 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) begin
                add_Done <= 1'b1;
                add_R    <= a_res;
            end
        end
    end

    int   mul_cycles = 0, add_cycles = 0;
    int   muls_at_rise[$];
    logic add_done_prev = 1'b0;

    always @(negedge clk) begin
        if (mul_Reset) mul_cycles <= mul_cycles + 1;
        if (add_Reset) add_cycles <= add_cycles + 1;
        if (add_Done && !add_done_prev) muls_at_rise.push_back(mul_cycles + (mul_Reset ? 1 : 0));
        add_done_prev <= add_Done;
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_job(input curve_point_t p, input logic [SCALAR_WIDTH-1:0] k, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_P     = p;
        in_k     = k;
        in_last  = last;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) note_timeout("in_ready_wait");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_output(input int stall, output curve_point_t r, output logic [CW-1:0] c);
        int n = 0;
        while (!out_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) note_timeout("out_valid_wait");
        r = out_R;
        c = out_count;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_batch(input job_t jq[$], input int stall, input bit gaps,
                             output curve_point_t r, output logic [CW-1:0] c,
                             output int muls, output int adds);
        int m0 = mul_cycles;
        int a0 = add_cycles;
        foreach (jq[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_job(jq[i].P, jq[i].k, i == jq.size() - 1);
        end
        get_output(stall, r, c);
        muls = mul_cycles - m0;
        adds = add_cycles - a0;
    endtask

    // Reference: the batch result is just the sum of k_i*P_i; pulse counts follow from
    // which scalars need a real multiply and how many non-zero products must be combined.
    task automatic model(input job_t jq[$], output curve_point_t r, output int c,
                         output int muls, output int adds);
        logic [31:0] sx = 0, sy = 0;
        int nz = 0;
        muls = 0;
        foreach (jq[i]) begin
            sx += 32'(jq[i].P.x) * 32'(jq[i].k);
            sy += 32'(jq[i].P.y) * 32'(jq[i].k);
            if (jq[i].k > 1) muls++;
            if (jq[i].k != 0) nz++;
        end
        r    = '{x: sx[15:0], y: sy[15:0]};
        c    = jq.size() % (1 << CW);
        adds = (nz > 0) ? nz - 1 : 0;
    endtask

    vec_t tbl[6];

    task automatic add_job(input int v, input curve_point_t p, input logic [SCALAR_WIDTH-1:0] k);
        tbl[v].j[tbl[v].n] = '{P: p, k: k};
        tbl[v].n++;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        curve_point_t G, G2, G3, G4, G5, G7, G10;
        curve_point_t r, r_exp, r0;
        logic [CW-1:0] c, c0;
        int muls, adds, c_exp, m_exp, a_exp, n, rises0, m0;
        job_t jq[$];

        G   = '{x: 16'h1234, y: 16'h0567};
        G2  = '{x: 16'h2468, y: 16'h0ACE};
        G3  = '{x: 16'h369C, y: 16'h1035};
        G4  = '{x: 16'h48D0, y: 16'h159C};
        G5  = '{x: 16'h5B04, y: 16'h1B03};
        G7  = '{x: 16'h7F6C, y: 16'h25D1};
        G10 = '{x: 16'hB608, y: 16'h3606};

        for (int v = 0; v < 6; v++) tbl[v].n = 0;
        add_job(0, G, 3);
        tbl[0].exp_R = G3;        tbl[0].exp_cnt = 1; tbl[0].exp_muls = 1; tbl[0].exp_adds = 0;
        add_job(1, G, 2); add_job(1, G, 5);
        tbl[1].exp_R = G7;        tbl[1].exp_cnt = 2; tbl[1].exp_muls = 2; tbl[1].exp_adds = 1;
        add_job(2, G, 0); add_job(2, G, 1);
        tbl[2].exp_R = G;         tbl[2].exp_cnt = 2; tbl[2].exp_muls = 0; tbl[2].exp_adds = 0;
        add_job(3, G, 0); add_job(3, G2, 0);
        tbl[3].exp_R = inf_point; tbl[3].exp_cnt = 2; tbl[3].exp_muls = 0; tbl[3].exp_adds = 0;
        add_job(4, G2, 1); add_job(4, G, 0); add_job(4, G, 3);
        tbl[4].exp_R = G5;        tbl[4].exp_cnt = 3; tbl[4].exp_muls = 1; tbl[4].exp_adds = 1;
        for (int i = 0; i < 9; i++) add_job(5, G, 0);
        tbl[5].exp_R = inf_point; tbl[5].exp_cnt = 1; tbl[5].exp_muls = 0; tbl[5].exp_adds = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_mul_Reset", 64'(mul_Reset), 0);
        check("rst_add_Reset", 64'(add_Reset), 0);
        check("rst_out_count", 64'(out_count), 0);
        check("rst_out_R", 64'(out_R), 64'(inf_point));
        check("rst_mul_k", 64'(mul_k), 0);
        check("rst_add_Q", 64'(add_Q), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 1);

        // Directed batch table
        for (int v = 0; v < 6; v++) begin
            jq.delete();
            for (int i = 0; i < tbl[v].n; i++) jq.push_back(tbl[v].j[i]);
            run_batch(jq, 0, 1'b0, r, c, muls, adds);
            check($sformatf("tbl%0d_out_R", v), 64'(r), 64'(tbl[v].exp_R));
            check($sformatf("tbl%0d_out_count", v), 64'(c), 64'(tbl[v].exp_cnt));
            check($sformatf("tbl%0d_mul_pulses", v), 64'(muls), 64'(tbl[v].exp_muls));
            check($sformatf("tbl%0d_add_pulses", v), 64'(adds), 64'(tbl[v].exp_adds));
        end

        // Overlap: the third multiply must launch while the first add is still running.
        mul_lat = 3;
        add_lat = 12;
        rises0 = muls_at_rise.size();
        m0 = mul_cycles;
        jq = '{'{P: G, k: 2}, '{P: G, k: 3}, '{P: G, k: 5}};
        run_batch(jq, 0, 1'b0, r, c, muls, adds);
        check("ovl_out_R", 64'(r), 64'(G10));
        check("ovl_out_count", 64'(c), 3);
        check("ovl_add_pulses", 64'(adds), 2);
        if (muls_at_rise.size() > rises0)
            check("ovl_muls_before_add_done", 64'(muls_at_rise[rises0] - m0), 3);
        else
            note_timeout("ovl_add_done_seen");

        // Output back-pressure: result and count frozen, no new jobs accepted.
        mul_lat = 2;
        add_lat = 2;
        send_job(G, 3, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) note_timeout("stall_out_valid_wait");
        r0 = out_R;
        c0 = out_count;
        check("stall_first_R", 64'(r0), 64'(G3));
        check("stall_first_count", 64'(c0), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_out_valid", i), 64'(out_valid), 1);
            check($sformatf("stall%0d_out_R", i), 64'(out_R), 64'(G3));
            check($sformatf("stall%0d_out_count", i), 64'(out_count), 1);
            check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_release_in_ready", 64'(in_ready), 1);
        check("stall_release_count", 64'(out_count), 0);

        // Reset during M_RUN of (G,7); the stale done that follows must be ignored.
        mul_lat = 8;
        send_job(G, 7, 1'b1);
        n = 0;
        while (!mul_Reset && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mul_Reset) note_timeout("rst_mid_mul_Reset_wait");
        repeat (3) @(negedge clk);
        Reset_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 64'(in_ready), 0);
        check("rst_mid_out_count", 64'(out_count), 0);
        check("rst_mid_mul_k", 64'(mul_k), 0);
        check("rst_mid_mul_Reset", 64'(mul_Reset), 0);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_mid_stale_done_present", 64'(mul_Done), 1);
        jq = '{'{P: G, k: 4}};
        run_batch(jq, 0, 1'b0, r, c, muls, adds);
        check("rst_mid_out_R", 64'(r), 64'(G4));
        check("rst_mid_out_count", 64'(c), 1);
        check("rst_mid_mul_pulses", 64'(muls), 1);

        // Randomized batches against the sum-of-products model
        for (int b = 0; b < 40; b++) begin
            int len, sel;
            mul_lat = $urandom_range(1, 5);
            add_lat = $urandom_range(1, 5);
            len = $urandom_range(1, 5);
            jq.delete();
            for (int i = 0; i < len; i++) begin
                job_t jb;
                sel  = $urandom_range(0, 99);
                jb.P = curve_point_t'($urandom);
                jb.k = (sel < 25) ? '0 : (sel < 40) ? SCALAR_WIDTH'(1)
                                   : SCALAR_WIDTH'($urandom_range(2, 65535));
                jq.push_back(jb);
            end
            model(jq, r_exp, c_exp, m_exp, a_exp);
            run_batch(jq, $urandom_range(0, 3), 1'b1, r, c, muls, adds);
            check($sformatf("rnd%0d_out_R", b), 64'(r), 64'(r_exp));
            check($sformatf("rnd%0d_out_count", b), 64'(c), 64'(c_exp));
            check($sformatf("rnd%0d_mul_pulses", b), 64'(muls), 64'(m_exp));
            check($sformatf("rnd%0d_add_pulses", b), 64'(adds), 64'(a_exp));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/point_mul_dispatcher.md
POINT_MUL_DISPATCHER -- requirements
Module: point_mul_dispatcher

Interface
REQ-001 Parameter: COUNT_W, default 16, width of the job counter.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 Reset_n  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  job (in_P, in_k, in_last) offered.
REQ-005 in_ready  out  1  job accepted when in_valid&in_ready.
REQ-006 in_P  in  curve_point_t  base point.
REQ-007 in_k  in  SCALAR_WIDTH  scalar.
REQ-008 in_last  in  1  final job of the current MSM batch.
REQ-009 out_valid  out  1  batch sum available.
REQ-010 out_ready  in  1  consumer accepts when out_valid&out_ready.
REQ-011 out_R  out  curve_point_t  sum of k_i*P_i over the batch.
REQ-012 out_count  out  COUNT_W  jobs in the batch, wraps modulo 2^COUNT_W.
REQ-013 mul_Reset  out  1  start pulse to the scalar multiplier (active-high).
REQ-014 mul_P, mul_k  out  curve_point_t, SCALAR_WIDTH  multiplier operands.
REQ-015 mul_Done, mul_R  in  1, curve_point_t  multiplier completion level and result.
REQ-016 add_Reset  out  1  start pulse to the point adder (active-high).
REQ-017 add_P, add_Q  out  curve_point_t  adder operands.
REQ-018 add_Done, add_R  in  1, curve_point_t  adder completion level and result.

Function
REQ-019 Two concurrent FSMs SHALL run: MUL (M_IDLE, M_START, M_BLANK, M_RUN, M_HOLD) and ACC (A_IDLE, A_START, A_BLANK, A_RUN, A_OUT).
REQ-020 in_ready SHALL be 1 only in M_IDLE with no pending last job.
REQ-021 On accept, P, k and last SHALL be registered; mul_P/mul_k SHALL hold these values, stable until mul_Done is consumed.
REQ-022 If k==0, no multiply and no add SHALL occur; only the counter increments.
REQ-023 If k==1, no multiply SHALL occur; the product SHALL equal P and go straight to M_HOLD.
REQ-024 Otherwise M_START SHALL drive mul_Reset=1 for exactly one cycle.
REQ-025 M_BLANK SHALL follow M_START for one cycle; mul_Done is ignored there.
REQ-026 In M_RUN, mul_Done=1 SHALL latch mul_R into the product register and move to M_HOLD.
REQ-027 M_HOLD SHALL hand the product to ACC when ACC is in A_IDLE, then return to M_IDLE in the same cycle.
REQ-028 Overlap: a new job SHALL be accepted and multiplied while ACC is busy with the previous product.
REQ-029 ACC SHALL set add_P=accumulator, add_Q=product, pulse add_Reset for one cycle (A_START), blank one cycle (A_BLANK), and latch add_R into the accumulator on add_Done in A_RUN.
REQ-030 First non-trivial product of a batch SHALL be loaded into the accumulator directly, with no add (accumulator was inf_point).
REQ-031 out_count SHALL increment once per accepted job, including k==0 and k==1 jobs.
REQ-032 After the last job's contribution is accumulated (or skipped), ACC SHALL enter A_OUT with out_valid=1; out_R and out_count SHALL be held stable until out_ready.
REQ-033 On the output handshake, the accumulator SHALL clear to inf_point, the count SHALL clear to 0, and in_ready SHALL be re-enabled.
REQ-034 A batch with every k==0 SHALL output out_R=inf_point.
REQ-035 Product latency per job = multiplier cycles + 2; the add stage hides behind the next multiply.

Reset
REQ-036 Reset_n=0 SHALL immediately force: both FSMs to their idle states; in_ready=0 while asserted; out_valid=0; mul_Reset=0; add_Reset=0; accumulator=inf_point; out_count=0; operand registers=0.
REQ-037 Reset mid-operation SHALL abandon all in-flight work; mul_Done/add_Done SHALL be ignored until a fresh start pulse.

Structure
REQ-038 curve_point_t, inf_point and SCALAR_WIDTH SHALL come from elliptic_curve_structs; no new package types.
REQ-039 One sub-module SHALL exist: dispatcher_start_pulse (start/blank/run sequencer), instantiated twice (multiplier and adder).
REQ-040 The multiplier and adder SHALL stay outside this block; they are connected at the top level.

Verification
REQ-041 Single job (G, 3, last) -> out_R=3G, out_count=1, exactly one mul_Reset pulse and no add_Reset.
REQ-042 Jobs (G,2), (G,5,last) -> out_R=7G, out_count=2; second mul_Reset asserted before the first add_Done.
REQ-043 Jobs (G,0), (G,1,last) -> out_R=G, out_count=2, zero mul_Reset and zero add_Reset pulses.
REQ-044 out_ready held 0 for 10 cycles after out_valid -> out_R/out_count stable, in_ready=0 throughout.
REQ-045 Reset_n pulsed low during M_RUN of (G,7), then job (G,4,last) -> out_R=4G, out_count=1.
REQ-046 Jobs (G,0), (2G,0,last) -> out_R=inf_point, out_count=2.
